stack_unit: RTL
===============

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter: WIDTH, 32, data word width in bits.
REQ-002 Parameter: DEPTH, 16, number of stack entries; SHALL be a power of two, at least 2.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: push  input  1  push request from the processor control unit; sampled each rising edge.
REQ-006 Port: pop  input  1  pop request from the processor control unit; sampled each rising edge.
REQ-007 Port: din  input  WIDTH  data to push.
REQ-008 Port: clr_err  input  1  clears the fault state and the sticky error flags.
REQ-009 Port: dout  output  WIDTH  registered popped word.
REQ-010 Port: dout_valid  output  1  one-cycle pulse: dout was updated by a pop.
REQ-011 Port: count  output  log2(DEPTH)+1  number of valid entries.
REQ-012 Port: full, empty  output  1 each  count==DEPTH and count==0, respectively.
REQ-013 Port: ovf, unf  output  1 each  sticky overflow and sticky underflow flags.
REQ-014 Port: halt_req  output  1  high while in FAULT; the processor stops issuing instructions.

Function
REQ-015 Internal stack pointer sp = count; push writes mem[sp] then sp+1; pop reads mem[sp-1] then sp-1.
REQ-016 FSM states: RUN and FAULT; reset enters RUN.
REQ-017 RUN, push only, not full: write din, count+1, and no dout change.
REQ-018 RUN, pop only, not empty: dout<=top, dout_valid=1 next cycle, count-1.
REQ-019 RUN, push and pop, not empty: dout<=old top, dout_valid=1, top overwritten with din, count unchanged.
REQ-020 RUN, push and pop, empty: treat as push only; unf<=1; go to FAULT.
REQ-021 RUN, push when full: no write, count unchanged, ovf<=1; go to FAULT.
REQ-022 RUN, pop when empty: dout unchanged, dout_valid=0, unf<=1; go to FAULT.
REQ-023 FAULT: push and pop are ignored; halt_req=1; contents, count and dout are held.
REQ-024 FAULT with clr_err=1: ovf<=0, unf<=0; go to RUN the next cycle; stack contents are kept.
REQ-025 clr_err in RUN: clears ovf and unf only; a push/pop in the same cycle executes normally.
REQ-026 full and empty are combinational from count; there is no wrap-around, and sp is always between 0 and DEPTH.
REQ-027 dout_valid SHALL never be high for two consecutive cycles unless pops are issued on consecutive cycles.
REQ-028 Latency: data popped in cycle N is on dout in cycle N+1; data pushed in cycle N is poppable in cycle N+1.

Reset
REQ-029 reset low, asynchronous: count=0, dout=0, dout_valid=0, ovf=0, unf=0, state=RUN, halt_req=0.
REQ-030 Reset mid-operation: any in-flight push/pop is discarded, and the storage array is not cleared.
REQ-031 Reset deassertion SHALL be synchronised externally; the first push is accepted on the first edge with reset high.

Structure
REQ-032 Shared package stack_pkg: WIDTH and DEPTH defaults, SP_W=log2(DEPTH)+1, and the state enum {RUN, FAULT}.
REQ-033 Sub-module stack_ram: DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port; it has no reset.
REQ-034 stack_unit holds the FSM, count, flags and the dout register; the code is 120-400 RTL lines.

Verification
REQ-035 Reset, then push 0xA, 0xB, 0xC on consecutive cycles, then pop x3 -> dout 0xC, 0xB, 0xA with dout_valid pulses; empty=1 at the end.
REQ-036 Push 16 words 0..15, then push 0xFF -> full=1, ovf=1, halt_req=1, count=16; then pop -> ignored; clr_err -> RUN; pop -> dout=15.
REQ-037 From empty, pop -> unf=1, FAULT, dout_valid=0; from empty, push+pop with din=0x5 -> count=1, unf=1.
REQ-038 Stack [0x1,0x2], push+pop with din=0x9 -> dout=0x2, count=2; next pop -> dout=0x9.
REQ-039 Push 0x3, 0x4, then assert reset low mid-cycle -> count=0, dout=0, flags 0 immediately; pop after release -> unf=1.

Source files
------------

// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the hardware stack unit: default geometry, the
// stack-pointer width derived from it, and the controller state encoding.
// -----------------------------------------------------------------------------
package stack_pkg;

  // Default data word width in bits.
  localparam int STACK_WIDTH = 32;

  // Default number of entries; must be a power of two and at least 2.
  localparam int STACK_DEPTH = 16;

  // One extra bit so the pointer can represent 0..DEPTH inclusive.
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  // Controller state: normal operation or halted on an overflow/underflow.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

endpackage : stack_pkg

// File: rtl/stack_ram.sv
// -----------------------------------------------------------------------------
// stack_ram
// DEPTH x WIDTH storage for the stack. One synchronous write port and one
// asynchronous (combinational) read port. There is deliberately no reset:
// contents survive a controller reset and are only changed by writes.
//
// Ports
//   clk      : write clock
//   we_i     : write enable, sampled on the rising edge
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data, combinational from raddr_i
// -----------------------------------------------------------------------------
module stack_ram
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]           rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Synchronous write port; storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : stack_ram

// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
// Hardware LIFO stack for a processor control unit. Supports push, pop and a
// combined push+pop (replace top, return old top). Overflow and underflow
// move the controller into a FAULT state that raises halt_req until clr_err.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous active-low reset
//   push       : push request
//   pop        : pop request
//   din        : data to push
//   clr_err    : clears sticky flags and leaves FAULT
//   dout       : registered popped word
//   dout_valid : one-cycle pulse, dout was updated by a pop
//   count      : number of valid entries (0..DEPTH)
//   full       : count == DEPTH
//   empty      : count == 0
//   ovf        : sticky overflow flag
//   unf        : sticky underflow flag
//   halt_req   : high while in FAULT
// -----------------------------------------------------------------------------
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  output logic                     unf,
  output logic                     halt_req
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q;
  logic [CNT_W-1:0]   count_q;      // doubles as the stack pointer
  logic [WIDTH-1:0]   dout_q;
  logic               dout_valid_q;
  logic               ovf_q;
  logic               unf_q;
  logic               halt_q;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic               full_s;
  logic               empty_s;
  logic               run_s;
  logic [AW-1:0]      top_addr_s;
  logic               wr_swap_s;
  logic               wr_push_s;
  logic               ram_we_s;
  logic [AW-1:0]      ram_waddr_s;
  logic [WIDTH-1:0]   rd_data_s;

  assign full_s  = (count_q == CNT_W'(DEPTH));
  assign empty_s = (count_q == {CNT_W{1'b0}});
  assign run_s   = (state_q == RUN);

  // Index of the current top entry. When full the low bits wrap to zero, so
  // subtracting one in the narrow width still lands on DEPTH-1.
  assign top_addr_s = count_q[AW-1:0] - AW'(1);

  // Write-enable and write-address selection for the storage array.
  always_comb begin
    wr_swap_s   = 1'b0;
    wr_push_s   = 1'b0;
    ram_waddr_s = count_q[AW-1:0];
    if (run_s && push) begin
      if (pop) begin
        if (!empty_s) begin
          // Replace the top entry in place; the old value is popped.
          wr_swap_s = 1'b1;
        end else begin
          // Push+pop on an empty stack still performs the push.
          wr_push_s = 1'b1;
        end
      end else begin
        if (!full_s) begin
          wr_push_s = 1'b1;
        end else begin
          wr_push_s = 1'b0;
        end
      end
    end else begin
      wr_swap_s = 1'b0;
      wr_push_s = 1'b0;
    end
    if (wr_swap_s) begin
      ram_waddr_s = top_addr_s;
    end else begin
      ram_waddr_s = count_q[AW-1:0];
    end
  end

  assign ram_we_s = wr_swap_s | wr_push_s;

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we_s),
    .waddr_i (ram_waddr_s),
    .wdata_i (din),
    .raddr_i (top_addr_s),
    .rdata_o (rd_data_s)
  );

  // ---------------------------------------------------------------------------
  // Controller FSM with pointer, flags and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      count_q      <= {CNT_W{1'b0}};
      dout_q       <= {WIDTH{1'b0}};
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      halt_q       <= 1'b0;
    end else begin
      // dout_valid is a pulse; only a successful pop raises it again.
      dout_valid_q <= 1'b0;
      case (state_q)
        RUN: begin
          // Clear first so that an error in the same cycle still sets its flag.
          if (clr_err) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
          end
          if (push && pop) begin
            if (!empty_s) begin
              dout_q       <= rd_data_s;
              dout_valid_q <= 1'b1;
            end else begin
              count_q <= count_q + CNT_W'(1);
              unf_q   <= 1'b1;
              state_q <= FAULT;
              halt_q  <= 1'b1;
            end
          end else if (push) begin
            if (!full_s) begin
              count_q <= count_q + CNT_W'(1);
            end else begin
              ovf_q   <= 1'b1;
              state_q <= FAULT;
              halt_q  <= 1'b1;
            end
          end else if (pop) begin
            if (!empty_s) begin
              dout_q       <= rd_data_s;
              dout_valid_q <= 1'b1;
              count_q      <= count_q - CNT_W'(1);
            end else begin
              unf_q   <= 1'b1;
              state_q <= FAULT;
              halt_q  <= 1'b1;
            end
          end
        end
        FAULT: begin
          // Everything is frozen until software acknowledges the fault.
          if (clr_err) begin
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            state_q <= RUN;
            halt_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= FAULT;
          halt_q  <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;
  assign full       = full_s;
  assign empty      = empty_s;
  assign ovf        = ovf_q;
  assign unf        = unf_q;
  assign halt_req   = halt_q;

endmodule : stack_unit
